// File: rtl/ahb_slave_port_arbiter_pkg.sv
// ahb_slave_port_arbiter_pkg: burst/arbitration types and burst length decode for the per-slave arbiter
package ahb_slave_port_arbiter_pkg;
  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } hburst_type;
  typedef enum logic [1:0] {ARB_FIXED, ARB_ROUND_ROBIN, ARB_DYNAMIC} arb_mode_e;
  typedef enum logic {ST_IDLE, ST_OWN} arb_state_e;
  localparam int CNT_W = 9;
  function automatic logic [CNT_W-1:0] burst_beats(hburst_type b, int incr_max);
    return b == SINGLE ? CNT_W'(1) :
           b == INCR ? CNT_W'(incr_max) :
           (b == WRAP4 || b == INCR4) ? CNT_W'(4) :
           (b == WRAP8 || b == INCR8) ? CNT_W'(8) : CNT_W'(16);
  endfunction
endpackage

// File: rtl/ahb_slave_port_arbiter_if.sv
// ahb_slave_port_arbiter_if: request/grant bundle between master-side decoders and one slave port
interface ahb_slave_port_arbiter_if
  import ahb_slave_port_arbiter_pkg::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int PRIOR_BIT  = 2
);
  logic [MASTER_NUM-1:0]                hreq;
  hburst_type [MASTER_NUM-1:0]          hburst;
  logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] hprior;
  logic                                 hwait;
  logic [MASTER_NUM-1:0]                hgrant;
  logic                                 hsel;
  logic [$clog2(MASTER_NUM)-1:0]        hmaster;
  logic                                 hlast;
  modport master (output hreq, hburst, hprior, hwait, input hgrant, hsel, hmaster, hlast);
  modport slave  (input hreq, hburst, hprior, hwait, output hgrant, hsel, hmaster, hlast);
endinterface

// File: rtl/ahb_slave_port_arbiter_pick.sv
// ahb_arb_pick: combinational winner selection (fixed, round-robin or priority) with optional exclusion
module ahb_arb_pick
  import ahb_slave_port_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PB = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_excl,
  input  logic [IW-1:0]        i_rr_ptr,
  input  logic [N-1:0][PB-1:0] i_prior,
  input  arb_mode_e            i_mode,
  output logic [N-1:0]         o_onehot,
  output logic [IW-1:0]        o_idx
);
  logic [N-1:0]  w_cand;
  logic          w_found;
  logic [PB-1:0] w_best;
  int            w_i;
  function automatic int wrap(int a);
    return a >= N ? a - N : a;
  endfunction
  // the excluded master only loses when someone else is asking
  always_comb begin
    w_cand = |(i_req & ~i_excl) ? i_req & ~i_excl : i_req;
    w_found = 1'b0;
    w_best = '0;
    w_i = 0;
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_i = i_mode == ARB_ROUND_ROBIN ? wrap(int'(i_rr_ptr) + k) : k;
      if (w_cand[w_i] && (!w_found || (i_mode == ARB_DYNAMIC && i_prior[w_i] > w_best))) begin
        w_found = 1'b1;
        w_best = i_prior[w_i];
        o_idx = IW'(w_i);
      end
    end
    o_onehot = w_found ? N'(1) << o_idx : '0;
  end
endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// ahb_slave_port_arbiter: per-slave AHB arbiter with burst-length tracking and capped INCR bursts
module ahb_slave_port_arbiter
  import ahb_slave_port_arbiter_pkg::*;
#(
  parameter int        MASTER_NUM  = 4,
  parameter int        PRIOR_LEVEL = 4,
  parameter int        PRIOR_BIT   = $clog2(PRIOR_LEVEL),
  parameter arb_mode_e ARB_MODE    = ARB_ROUND_ROBIN,
  parameter int        INCR_MAX    = 16
) (
  input logic hclk,
  input logic hreset_n,
  ahb_slave_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(MASTER_NUM);
  arb_state_e            r_state, w_state_nxt;
  logic [MASTER_NUM-1:0] r_grant, w_win_oh, w_excl;
  logic [IW-1:0]         r_master, r_rr_ptr, w_ptr, w_win_idx;
  logic [CNT_W-1:0]      r_cnt, r_len;
  logic                  r_incr, w_own, w_final, w_grant;
  ahb_arb_pick #(.N(MASTER_NUM), .PB(PRIOR_BIT), .IW(IW)) u_pick (
    .i_req(bus.hreq), .i_excl(w_excl), .i_rr_ptr(w_ptr), .i_prior(bus.hprior),
    .i_mode(ARB_MODE), .o_onehot(w_win_oh), .o_idx(w_win_idx)
  );
  // re-arbitration on the final beat sees the already-advanced round-robin pointer
  always_comb begin
    w_own = r_state == ST_OWN;
    w_final = w_own & ~bus.hwait & ((r_cnt == r_len - 1'b1) | (r_incr & ~bus.hreq[r_master]));
    w_ptr = w_final ? (r_master == IW'(MASTER_NUM - 1) ? '0 : r_master + 1'b1) : r_rr_ptr;
    w_excl = w_final ? r_grant : '0;
    w_grant = (~w_own | w_final) & |bus.hreq;
    w_state_nxt = w_grant ? ST_OWN : w_final ? ST_IDLE : r_state;
  end
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) begin
      r_grant <= '0;
      r_master <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_incr <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_ptr;
      if (w_grant) begin
        r_grant <= w_win_oh;
        r_master <= w_win_idx;
        r_cnt <= '0;
        r_len <= burst_beats(bus.hburst[w_win_idx], INCR_MAX);
        r_incr <= bus.hburst[w_win_idx] == INCR;
      end else if (w_final) r_grant <= '0;
      else if (w_own & ~bus.hwait) r_cnt <= r_cnt + 1'b1;
    end
  assign bus.hgrant = r_grant & {MASTER_NUM{~bus.hwait}};
  assign bus.hsel = |r_grant;
  assign bus.hmaster = r_master;
  assign bus.hlast = w_final;
endmodule
